spi_byte_master: RTL

//  Sequences a divided serial clock into complete SPI transactions (mode 0/2 phase, CPHA=0).

---
 rtl/spi_pkg.sv | 36 +++
 rtl/spi_edge_timer.sv | 33 +++
 rtl/spi_byte_master.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: one-hot state encoding, derived timing widths and
// parameter legality helpers reused by SPI masters built on the same timer.
package spi_pkg;

    // One-hot sequencing states; IDLE is the all-zero code.
    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0000,
        ST_SETUP = 4'b0001,
        ST_SHIFT = 4'b0010,
        ST_HOLD  = 4'b0100,
        ST_GAP   = 4'b1000
    } spi_state_e;

    // Number of clk cycles per sclk half-period.
    function automatic int unsigned half_period(input int unsigned div);
        return div / 32'd2;
    endfunction

    // Width of the half-period counter: ceil(log2(H+1)).
    function automatic int unsigned hp_cnt_width(input int unsigned div);
        return $clog2((div / 32'd2) + 32'd1);
    endfunction

    // Width of the half-period index counter: ceil(log2(2*WIDTH)), at least 1.
    function automatic int unsigned bit_cnt_width(input int unsigned width);
        int unsigned w;
        w = $clog2(32'd2 * width);
        return (w < 32'd1) ? 32'd1 : w;
    endfunction

    // DIV must be even and at least 2; WIDTH must be at least 1.
    function automatic bit params_legal(input int unsigned div, input int unsigned width);
        return (div >= 32'd2) && ((div % 32'd2) == 32'd0) && (width >= 32'd1);
    endfunction

endpackage

// File: rtl/spi_edge_timer.sv
// Half-period timer: counts H clock cycles while run is high and flags the last
// cycle of every half-period with tick. Dropping run clears the count so each
// transaction starts on a clean half-period boundary.
module spi_edge_timer #(
    parameter int unsigned H     = 32'd4,
    parameter int unsigned CNT_W = 32'd3
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic run,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(H - 32'd1);

    logic [CNT_W-1:0] cnt_r;

    // Half-period cycle counter, wrapping at H-1 and held at zero when idle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_r <= '0;
        end else if (!run) begin
            cnt_r <= '0;
        end else if (cnt_r == LAST_CNT) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + 1'b1;
        end
    end

    assign tick = run && (cnt_r == LAST_CNT);

endmodule

// File: rtl/spi_byte_master.sv
// SPI master for CPHA=0: frames one WIDTH-bit word per handshake with chip
// select, a half-period of setup, WIDTH sclk pulses, a half-period of hold and
// a half-period gap. MOSI leaves MSB first; MISO is sampled as sclk goes active.
module spi_byte_master
    import spi_pkg::*;
#(
    parameter int unsigned DIV   = 32'd8,
    parameter bit          CPOL  = 1'b0,
    parameter int unsigned WIDTH = 32'd8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] data_o,
    output logic             sclk_o,
    output logic             mosi_o,
    input  logic             miso_i,
    output logic             cs_n_o
);

    localparam int unsigned H_C   = half_period(DIV);
    localparam int unsigned HP_W  = hp_cnt_width(DIV);
    localparam int unsigned BIT_W = bit_cnt_width(WIDTH);

    // Index of the final half-period and of the final active->idle transition.
    localparam logic [BIT_W-1:0] LAST_HP   = BIT_W'(32'd2 * WIDTH - 32'd1);
    localparam logic [BIT_W-1:0] LAST_FALL = BIT_W'(32'd2 * WIDTH - 32'd2);

    localparam logic SCLK_IDLE   = CPOL;
    localparam logic SCLK_ACTIVE = ~CPOL;

    generate
        if (!params_legal(DIV, WIDTH)) begin : g_bad_params
            $error("spi_byte_master: DIV must be even and >= 2, WIDTH must be >= 1");
        end
    endgenerate

    spi_state_e       state_r;
    spi_state_e       state_nxt_s;
    logic [BIT_W-1:0] hp_r;
    logic [BIT_W-1:0] hp_nxt_s;
    logic [WIDTH-1:0] tx_r;
    logic [WIDTH-1:0] tx_nxt_s;
    logic [WIDTH-1:0] rx_r;
    logic [WIDTH-1:0] rx_nxt_s;
    logic [WIDTH-1:0] data_r;
    logic [WIDTH-1:0] data_nxt_s;
    logic             sclk_r;
    logic             sclk_nxt_s;
    logic             mosi_r;
    logic             mosi_nxt_s;
    logic             cs_n_r;
    logic             cs_n_nxt_s;
    logic             done_r;
    logic             done_nxt_s;
    logic             run_s;
    logic             tick_s;
    logic [WIDTH:0]   tx_ext_s;
    logic [WIDTH:0]   rx_ext_s;

    // Shift helpers that stay legal for WIDTH == 1.
    assign tx_ext_s = {tx_r, 1'b0};
    assign rx_ext_s = {rx_r, miso_i};

    assign run_s = (state_r != ST_IDLE);

    spi_edge_timer #(
        .H     (H_C),
        .CNT_W (HP_W)
    ) u_timer (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .run   (run_s),
        .tick  (tick_s)
    );

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: every busy state advances only on a timer tick.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_i) state_nxt_s = ST_SETUP;
                else         state_nxt_s = ST_IDLE;
            end
            ST_SETUP: begin
                if (tick_s) state_nxt_s = ST_SHIFT;
                else        state_nxt_s = ST_SETUP;
            end
            ST_SHIFT: begin
                if (tick_s && (hp_r == LAST_HP)) state_nxt_s = ST_HOLD;
                else                             state_nxt_s = ST_SHIFT;
            end
            ST_HOLD: begin
                if (tick_s) state_nxt_s = ST_GAP;
                else        state_nxt_s = ST_HOLD;
            end
            ST_GAP: begin
                if (tick_s) state_nxt_s = ST_IDLE;
                else        state_nxt_s = ST_GAP;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output/datapath next values: pin levels, shift registers, half-period index.
    always_comb begin
        hp_nxt_s   = hp_r;
        tx_nxt_s   = tx_r;
        rx_nxt_s   = rx_r;
        data_nxt_s = data_r;
        sclk_nxt_s = sclk_r;
        mosi_nxt_s = mosi_r;
        cs_n_nxt_s = cs_n_r;
        done_nxt_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                sclk_nxt_s = SCLK_IDLE;
                if (start_i) begin
                    tx_nxt_s   = data_i;
                    rx_nxt_s   = '0;
                    hp_nxt_s   = '0;
                    mosi_nxt_s = data_i[WIDTH-1];
                    cs_n_nxt_s = 1'b0;
                end else begin
                    mosi_nxt_s = 1'b0;
                    cs_n_nxt_s = 1'b1;
                end
            end
            ST_SETUP: begin
                if (tick_s) begin
                    // Entering half-period 0: idle->active edge samples MISO.
                    sclk_nxt_s = SCLK_ACTIVE;
                    rx_nxt_s   = rx_ext_s[WIDTH-1:0];
                end else begin
                    sclk_nxt_s = SCLK_IDLE;
                end
            end
            ST_SHIFT: begin
                if (tick_s) begin
                    if (hp_r == LAST_HP) begin
                        sclk_nxt_s = SCLK_IDLE;
                    end else begin
                        hp_nxt_s   = hp_r + 1'b1;
                        sclk_nxt_s = ~sclk_r;
                        if (hp_r[0] == 1'b0) begin
                            // Active->idle edge: advance MOSI, except after the last bit.
                            if (hp_r != LAST_FALL) begin
                                tx_nxt_s   = tx_ext_s[WIDTH-1:0];
                                mosi_nxt_s = tx_ext_s[WIDTH-1];
                            end else begin
                                mosi_nxt_s = mosi_r;
                            end
                        end else begin
                            // Idle->active edge: sample MISO.
                            rx_nxt_s = rx_ext_s[WIDTH-1:0];
                        end
                    end
                end else begin
                    hp_nxt_s = hp_r;
                end
            end
            ST_HOLD: begin
                if (tick_s) begin
                    cs_n_nxt_s = 1'b1;
                    mosi_nxt_s = 1'b0;
                    data_nxt_s = rx_r;
                    done_nxt_s = 1'b1;
                end else begin
                    cs_n_nxt_s = 1'b0;
                end
            end
            ST_GAP: begin
                cs_n_nxt_s = 1'b1;
                mosi_nxt_s = 1'b0;
                sclk_nxt_s = SCLK_IDLE;
            end
            default: begin
                cs_n_nxt_s = 1'b1;
                mosi_nxt_s = 1'b0;
                sclk_nxt_s = SCLK_IDLE;
            end
        endcase
    end

    // Datapath and pin registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hp_r   <= '0;
            tx_r   <= '0;
            rx_r   <= '0;
            data_r <= '0;
            sclk_r <= SCLK_IDLE;
            mosi_r <= 1'b0;
            cs_n_r <= 1'b1;
            done_r <= 1'b0;
        end else begin
            hp_r   <= hp_nxt_s;
            tx_r   <= tx_nxt_s;
            rx_r   <= rx_nxt_s;
            data_r <= data_nxt_s;
            sclk_r <= sclk_nxt_s;
            mosi_r <= mosi_nxt_s;
            cs_n_r <= cs_n_nxt_s;
            done_r <= done_nxt_s;
        end
    end

    assign ready_o = (state_r == ST_IDLE);
    assign busy_o  = (state_r != ST_IDLE);
    assign done_o  = done_r;
    assign data_o  = data_r;
    assign sclk_o  = sclk_r;
    assign mosi_o  = mosi_r;
    assign cs_n_o  = cs_n_r;

endmodule
